spi_reg_write_xn: RTL
=====================

SPI_REG_WRITE_XN -- requirements
Module: spi_reg_write_xn

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MODULE_ID, 0: index of this block's bit in cmd_busy/cmd_finish.
- CMD, 0: command code this block serves.
- MAX_BYTES, 8: maximum payload bytes per command, including the opcode (legal 1..16).
- TIMEOUT, 1024: cycles to wait in EX_REQ for spi_busy before declaring an error.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- flash_xx, in, 2: lane mode (0 = X1, 1 = X2, 2 = X4, 3 = treated as X1).
- cmd_request, in, 1: command strobe.
- cmd_code, in, 8: command code.
- cmd_nbytes, in, clog2(MAX_BYTES+1): payload byte count.
- cmd_payload, in, 8*MAX_BYTES: payload; byte 0 is in bits [7:0] and is sent first, MSB first.
- cmd_busy, out, MODULE_ID+1: only bit [MODULE_ID] is driven.
- cmd_finish, out, MODULE_ID+1: only bit [MODULE_ID] is driven.
- cmd_err, out, 1: error flag for the last command; sticky until the next accepted command.
- spi_request, out, 1: request to the SPI engine.
- spi_busy, in, 1: engine busy.
- spi_req_len, out, 24: SPI clock count for the transfer.
- spi_req_wr_len, out, 24: equals spi_req_len.
- spi_req_cmd, out, 3: 3'b001 in X1, 3'b000 otherwise.
- spi_wr_vld, out, 1: write beat valid.
- spi_wr_ready, in, 1: engine ready for a beat.
- spi_clk_en, in, 1: engine clock enable.
- spi_wr_data, out, 8: lane-packed beat.

Function
REQ-003 Command accept: cmd_request=1, cmd_code==CMD and state IDLE. Command fields are sampled only at accept.
REQ-004 At accept, cmd_payload, cmd_nbytes and flash_xx are latched. Changes to these inputs mid-command have no effect.
REQ-005 Main FSM states and transitions:
- IDLE -> EX_REQ on accept with 1 <= nbytes <= MAX_BYTES.
- IDLE -> ERR on accept with nbytes = 0 or nbytes > MAX_BYTES. No SPI request is issued.
- EX_REQ -> REQ_EXEC when spi_busy=1.
- EX_REQ -> ERR when the wait counter reaches TIMEOUT without spi_busy.
- REQ_EXEC -> REQ_FSH when spi_busy=0 and all beats have been accepted.
- REQ_FSH -> IDLE and ERR -> IDLE unconditionally.
REQ-006 All outputs are registered and decoded from the next state, so each output takes effect one cycle after its state transition is decided.
REQ-007 cmd_busy[MODULE_ID] is 1 while in EX_REQ or REQ_EXEC.
REQ-008 cmd_finish[MODULE_ID] is a 1-cycle pulse on entry to REQ_FSH or ERR. cmd_err is set on entry to ERR.
REQ-009 spi_request is 1 throughout EX_REQ and drops on entry to REQ_EXEC.
REQ-010 Beats per byte: X1 = 4, X2 = 2, X4 = 1. Total beats = nbytes * beats per byte, held in a counter of width clog2(4*MAX_BYTES+1).
REQ-011 spi_req_len = nbytes * 8 / lanes, where lanes is 1, 2 or 4. The value is latched at accept and held constant through REQ_FSH.
REQ-012 Beat acceptance = spi_wr_vld && spi_wr_ready && spi_clk_en.
REQ-013 spi_wr_vld is 1 in REQ_EXEC while beats remain. It falls in the cycle after the last beat is accepted and stays 0 until the next command.
REQ-014 spi_wr_data holds the current beat and advances only on beat acceptance. While stalled (wr_ready=0 or clk_en=0), data is held and no beat is lost or repeated.
REQ-015 Lane packing, taking bits MSB first (b0 is the earlier bit):
- X1: {3'b000, b0, 3'b000, b1}.
- X2: {2'b00, b0, b1, 2'b00, b2, b3}.
- X4: the full byte.
REQ-016 If spi_busy falls before all beats are accepted, the FSM goes to ERR: cmd_err=1, finish pulses, spi_wr_vld drops.
REQ-017 A cmd_request with a code other than CMD is ignored. A request while not in IDLE is ignored and never queued.

Reset
REQ-018 While rst=1 at a clock edge, the following take effect at that edge:
- FSM = IDLE;
- cmd_busy bit = 0, cmd_finish bit = 0, cmd_err = 0;
- spi_request = 0, spi_wr_vld = 0, spi_wr_data = 0, spi_req_len = 0;
- beat counter and timeout counter = 0.
REQ-019 Reset asserted mid-command aborts the command with no finish pulse. The first command after reset behaves identically to one issued from power-up.

Structure
REQ-020 Package spi_flash_pkg holds the lane-mode enum, the main FSM enum and the req_cmd constants.
REQ-021 Lane packing is implemented in a combinational sub-module, spi_lane_pack: inputs are byte, beat index and mode; output is the 8-bit beat.

Verification
REQ-022 Scenarios the bench must cover, with required responses:
- X4, nbytes=2, payload 0x61,0x47: req_len=4; beats 0x61, 0x47; single finish pulse; cmd_err=0.
- X1, nbytes=1, payload 0x61: req_len=8; beats 0x01, 0x10, 0x00, 0x01; req_cmd=3'b001.
- X2, nbytes=1, payload 0x47, wr_ready=0 for 3 cycles after the first beat: beats 0x10 then 0x13; 0x10 held through the stall.
- Error cases: nbytes=0 gives finish plus cmd_err=1 with no spi_request; spi_busy never asserting with TIMEOUT=16 gives ERR 16 cycles after entering EX_REQ.
- rst pulsed during the 3rd X1 beat: all outputs at reset values next cycle; a following X4 command completes normally.

Source files
------------

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_pkg
// Purpose  : Shared types for the SPI flash command blocks: lane-mode enum,
//            main command FSM enum, spi_req_cmd codes and a helper giving
//            log2(beats per byte) for each lane mode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

   typedef enum logic [1:0] {
      LANE_X1     = 2'd0,
      LANE_X2     = 2'd1,
      LANE_X4     = 2'd2,
      LANE_X1_ALT = 2'd3
   } lane_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EX_REQ   = 3'd1,
      ST_REQ_EXEC = 3'd2,
      ST_REQ_FSH  = 3'd3,
      ST_ERR      = 3'd4
   } main_state_t;

   localparam logic [2:0] REQ_CMD_X1 = 3'b001;
   localparam logic [2:0] REQ_CMD_XN = 3'b000;

   // X1 carries 2 bits per beat (4 beats/byte), X2 4 bits (2), X4 8 bits (1).
   function automatic logic [1:0] beat_shift(input lane_mode_t mode);
      case (mode)
         LANE_X2: return 2'd1;
         LANE_X4: return 2'd0;
         default: return 2'd2;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_lane_pack.sv
`default_nettype none
// ============================================================================
// Module   : spi_lane_pack
// Purpose  : Combinational lane packer. Selects the bits of one payload byte
//            that belong to a given beat (MSB first) and places them on the
//            data lanes of the 8-bit beat word.
// Ports    : data_byte - payload byte being sent
//            beat_idx  - beat number within the byte (0 = first)
//            mode      - lane mode (X1 / X2 / X4)
//            beat      - lane-packed beat word
// Revision : 1.0 - initial release
// ============================================================================
module spi_lane_pack
   import spi_flash_pkg::*;
(
   input  logic [7:0] data_byte,
   input  logic [1:0] beat_idx,
   input  lane_mode_t mode,
   output logic [7:0] beat
);

   logic [3:0] nib;
   logic [1:0] pair;

   always_comb begin
      nib = beat_idx[0] ? data_byte[3:0] : data_byte[7:4];
      case (beat_idx)
         2'd0:    pair = data_byte[7:6];
         2'd1:    pair = data_byte[5:4];
         2'd2:    pair = data_byte[3:2];
         default: pair = data_byte[1:0];
      endcase
      // Each beat holds two lane groups: earlier group in the upper nibble,
      // later group in the lower nibble, right-aligned within each nibble.
      case (mode)
         LANE_X4: beat = data_byte;
         LANE_X2: beat = {2'b00, nib[3:2], 2'b00, nib[1:0]};
         default: beat = {3'b000, pair[1], 3'b000, pair[0]};
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/spi_reg_write_xn.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_write_xn
// Purpose  : Serves one SPI flash "register write" command. Latches the
//            payload at accept, requests the SPI engine, streams lane-packed
//            write beats and reports busy/finish/error back to the host.
// Ports    : clock, rst               - clock, synchronous active-high reset
//            flash_xx                 - lane mode (0 X1, 1 X2, 2 X4, 3 X1)
//            cmd_request/code/nbytes/payload - host command interface
//            cmd_busy/finish[MODULE_ID], cmd_err - host status
//            spi_request, spi_busy    - engine request handshake
//            spi_req_len/wr_len/cmd   - transfer descriptor
//            spi_wr_vld/ready/clk_en/data - write beat stream
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_write_xn
   import spi_flash_pkg::*;
#(
   parameter int MODULE_ID = 0,
   parameter int CMD       = 0,
   parameter int MAX_BYTES = 8,
   parameter int TIMEOUT   = 1024
)(
   input  logic                           clock,
   input  logic                           rst,
   input  logic [1:0]                     flash_xx,
   input  logic                           cmd_request,
   input  logic [7:0]                     cmd_code,
   input  logic [$clog2(MAX_BYTES+1)-1:0] cmd_nbytes,
   input  logic [8*MAX_BYTES-1:0]         cmd_payload,
   output logic [MODULE_ID:0]             cmd_busy,
   output logic [MODULE_ID:0]             cmd_finish,
   output logic                           cmd_err,
   output logic                           spi_request,
   input  logic                           spi_busy,
   output logic [23:0]                    spi_req_len,
   output logic [23:0]                    spi_req_wr_len,
   output logic [2:0]                     spi_req_cmd,
   output logic                           spi_wr_vld,
   input  logic                           spi_wr_ready,
   input  logic                           spi_clk_en,
   output logic [7:0]                     spi_wr_data
);

   localparam int BEAT_W = $clog2(4*MAX_BYTES+1);
   localparam int TO_W   = $clog2(TIMEOUT+1);

   main_state_t                  state;
   lane_mode_t                   mode_q;
   lane_mode_t                   mode_in;
   logic [MAX_BYTES-1:0][7:0]    payload_q;
   logic [BEAT_W-1:0]            total_beats;
   logic [BEAT_W-1:0]            beat_cnt;
   logic [BEAT_W-1:0]            new_total;
   logic [BEAT_W-1:0]            pack_idx;
   logic [BEAT_W-1:0]            byte_idx;
   logic [TO_W-1:0]              wait_cnt;
   logic [23:0]                  new_len;
   logic [7:0]                   cur_byte;
   logic [7:0]                   pack_beat;
   logic [1:0]                   sub_idx;
   logic                         busy_q;
   logic                         finish_q;
   logic                         accept;
   logic                         nbytes_ok;
   logic                         beat_acc;
   logic                         last_beat;
   logic                         all_done;

   // Mode 3 is folded into X1 at latch time so downstream logic sees 3 modes.
   assign mode_in   = (flash_xx == 2'd3) ? LANE_X1 : lane_mode_t'(flash_xx);
   assign accept    = cmd_request && (cmd_code == 8'(CMD));
   assign nbytes_ok = (cmd_nbytes != '0) && (int'(cmd_nbytes) <= MAX_BYTES);
   assign new_total = BEAT_W'(cmd_nbytes) << beat_shift(mode_in);
   assign new_len   = 24'(cmd_nbytes) << (beat_shift(mode_in) + 2'd1);

   assign beat_acc  = spi_wr_vld && spi_wr_ready && spi_clk_en;
   assign last_beat = (beat_cnt == total_beats - BEAT_W'(1));
   assign all_done  = (beat_cnt == total_beats) || (beat_acc && last_beat);

   // Beat that will be shown next: beat 0 when entering REQ_EXEC, otherwise
   // the one after the beat currently on spi_wr_data.
   assign pack_idx = (state == ST_REQ_EXEC) ? beat_cnt + BEAT_W'(1) : '0;
   assign byte_idx = pack_idx >> beat_shift(mode_q);

   always_comb begin
      case (mode_q)
         LANE_X4: sub_idx = 2'd0;
         LANE_X2: sub_idx = {1'b0, pack_idx[0]};
         default: sub_idx = pack_idx[1:0];
      endcase
      cur_byte = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (byte_idx == BEAT_W'(i)) cur_byte = payload_q[i];
      end
   end

   spi_lane_pack u_lane_pack (
      .data_byte (cur_byte),
      .beat_idx  (sub_idx),
      .mode      (mode_q),
      .beat      (pack_beat)
   );

   always_comb begin
      cmd_busy              = '0;
      cmd_busy[MODULE_ID]   = busy_q;
      cmd_finish            = '0;
      cmd_finish[MODULE_ID] = finish_q;
   end

   assign spi_req_wr_len = spi_req_len;

   // Outputs are assigned together with the transition that enters the state
   // they belong to, so they appear one cycle after the decision.
   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= ST_IDLE;
         mode_q      <= LANE_X1;
         payload_q   <= '0;
         total_beats <= '0;
         beat_cnt    <= '0;
         wait_cnt    <= '0;
         busy_q      <= 1'b0;
         finish_q    <= 1'b0;
         cmd_err     <= 1'b0;
         spi_request <= 1'b0;
         spi_req_len <= '0;
         spi_req_cmd <= REQ_CMD_X1;
         spi_wr_vld  <= 1'b0;
         spi_wr_data <= '0;
      end else begin
         finish_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  payload_q   <= cmd_payload;
                  mode_q      <= mode_in;
                  total_beats <= new_total;
                  spi_req_len <= new_len;
                  spi_req_cmd <= (mode_in == LANE_X1) ? REQ_CMD_X1 : REQ_CMD_XN;
                  beat_cnt    <= '0;
                  wait_cnt    <= '0;
                  if (nbytes_ok) begin
                     state       <= ST_EX_REQ;
                     busy_q      <= 1'b1;
                     spi_request <= 1'b1;
                     cmd_err     <= 1'b0;
                  end else begin
                     state    <= ST_ERR;
                     finish_q <= 1'b1;
                     cmd_err  <= 1'b1;
                  end
               end
            end
            ST_EX_REQ: begin
               if (spi_busy) begin
                  state       <= ST_REQ_EXEC;
                  spi_request <= 1'b0;
                  spi_wr_vld  <= 1'b1;
                  spi_wr_data <= pack_beat;
               end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                  state       <= ST_ERR;
                  spi_request <= 1'b0;
                  busy_q      <= 1'b0;
                  finish_q    <= 1'b1;
                  cmd_err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
            end
            ST_REQ_EXEC: begin
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (last_beat) spi_wr_vld  <= 1'b0;
                  else           spi_wr_data <= pack_beat;
               end
               // Engine dropping busy ends the transfer; early drop is an error.
               if (!spi_busy) begin
                  busy_q     <= 1'b0;
                  finish_q   <= 1'b1;
                  spi_wr_vld <= 1'b0;
                  if (all_done) begin
                     state <= ST_REQ_FSH;
                  end else begin
                     state   <= ST_ERR;
                     cmd_err <= 1'b1;
                  end
               end
            end
            ST_REQ_FSH: state <= ST_IDLE;
            ST_ERR:     state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
